// File: rtl/xof_triple_unpacker_if.sv
// Handshake bundle between the Keccak squeeze port, the triple unpacker
// and the sample_ntt consumer. The unpacker uses the slave modport.
interface xof_triple_unpacker_if #(
   parameter int OCC_W = 5
);
   logic [127:0]     xof_squeeze_data_i;
   logic             xof_squeeze_valid_i;
   logic             xof_squeeze_last_i;
   logic             xof_squeeze_ready_o;
   logic [23:0]      triple_data_o;
   logic             triple_valid_o;
   logic             triple_last_o;
   logic             triple_ready_i;
   logic             flush_i;
   logic [OCC_W-1:0] occupancy_o;

   modport slave (
      input  xof_squeeze_data_i,
      input  xof_squeeze_valid_i,
      input  xof_squeeze_last_i,
      output xof_squeeze_ready_o,
      output triple_data_o,
      output triple_valid_o,
      output triple_last_o,
      input  triple_ready_i,
      input  flush_i,
      output occupancy_o
   );

   modport master (
      output xof_squeeze_data_i,
      output xof_squeeze_valid_i,
      output xof_squeeze_last_i,
      input  xof_squeeze_ready_o,
      input  triple_data_o,
      input  triple_valid_o,
      input  triple_last_o,
      output triple_ready_i,
      output flush_i,
      input  occupancy_o
   );
endinterface

// File: rtl/xof_triple_unpacker.sv
// Converts 16-byte Keccak squeeze beats into a stream of 3-byte groups.
// An 18-byte shift buffer holds at most two leftover bytes plus one beat,
// so groups straddling beat boundaries are reassembled without loss.
// Byte 0 of the buffer is always the oldest byte and sits in bits [7:0].
module xof_triple_unpacker #(
   parameter int IN_BYTES = 16,
   parameter int OCC_W    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   xof_triple_unpacker_if.slave bus
);
   localparam int BUF_W = (IN_BYTES + 2) * 8;

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             last_pend_q, last_pend_d;

   logic ready_s;
   logic valid_s;
   logic last_s;
   logic accept_s;
   logic pop_s;

   // Handshake qualifiers: space for a beat only with <=2 leftover bytes,
   // a triple only once 3 bytes are held; flush masks both sides.
   always_comb begin
      ready_s  = rst_n && !bus.flush_i && (occ_q <= OCC_W'(2));
      valid_s  = !bus.flush_i && (occ_q >= OCC_W'(3));
      last_s   = last_pend_q && (occ_q >= OCC_W'(3)) && (occ_q <= OCC_W'(5));
      accept_s = bus.xof_squeeze_valid_i && ready_s;
      pop_s    = valid_s && bus.triple_ready_i;
   end

   // Next-state for buffer, occupancy and pending-last flag; flush wins,
   // accept and pop are mutually exclusive by construction.
   always_comb begin
      buf_d       = buf_q;
      occ_d       = occ_q;
      last_pend_d = last_pend_q;
      if (bus.flush_i) begin
         occ_d       = {OCC_W{1'b0}};
         last_pend_d = 1'b0;
      end else if (accept_s) begin
         case (occ_q)
            OCC_W'(0): buf_d = {16'h0000, bus.xof_squeeze_data_i};
            OCC_W'(1): buf_d = {8'h00, bus.xof_squeeze_data_i, buf_q[7:0]};
            OCC_W'(2): buf_d = {bus.xof_squeeze_data_i, buf_q[15:0]};
            default:   buf_d = buf_q;
         endcase
         occ_d = occ_q + OCC_W'(IN_BYTES);
         if (bus.xof_squeeze_last_i) begin
            last_pend_d = 1'b1;
         end else begin
            last_pend_d = last_pend_q;
         end
      end else if (pop_s) begin
         buf_d = {24'h000000, buf_q[BUF_W-1:24]};
         if (last_s) begin
            // final triple of the stream: residual 0-2 bytes are dropped
            occ_d       = {OCC_W{1'b0}};
            last_pend_d = 1'b0;
         end else begin
            occ_d       = occ_q - OCC_W'(3);
            last_pend_d = last_pend_q;
         end
      end else begin
         buf_d       = buf_q;
         occ_d       = occ_q;
         last_pend_d = last_pend_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q       <= {BUF_W{1'b0}};
         occ_q       <= {OCC_W{1'b0}};
         last_pend_q <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         occ_q       <= occ_d;
         last_pend_q <= last_pend_d;
      end
   end

   assign bus.xof_squeeze_ready_o = ready_s;
   assign bus.triple_valid_o      = valid_s;
   assign bus.triple_last_o       = last_s;
   assign bus.triple_data_o       = buf_q[23:0];
   assign bus.occupancy_o         = occ_q;
endmodule

// File: tb/tb_xof_triple_unpacker.sv
// Self-checking bench for xof_triple_unpacker: directed scenarios with
// constant expectations, then a randomized run against a byte-queue model.
module tb_xof_triple_unpacker;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] act;
   logic [31:0] exp;

   xof_triple_unpacker_if #(.OCC_W(5)) bus();

   xof_triple_unpacker #(.IN_BYTES(16), .OCC_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // beat whose byte k is base+k
   function automatic logic [127:0] beat_of(input logic [7:0] base);
      logic [127:0] b;
      for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
      return b;
   endfunction

   // {squeeze_ready, valid, last, occupancy[4:0], data[23:0]}
   function automatic logic [31:0] obs();
      return {bus.xof_squeeze_ready_o, bus.triple_valid_o, bus.triple_last_o,
              bus.occupancy_o, bus.triple_data_o};
   endfunction

   task automatic test_reset();
      bus.xof_squeeze_valid_i = 1'b0;
      bus.xof_squeeze_data_i  = 128'h0;
      bus.xof_squeeze_last_i  = 1'b0;
      bus.triple_ready_i      = 1'b0;
      bus.flush_i             = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      act = obs(); n_checks++;
      if (act !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", act, 32'h0); end
      @(negedge clk); rst_n = 1'b1; #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_release: got %h expected %h", act, exp); end
   endtask

   task automatic test_first_beat();
      logic [7:0] s;
      @(negedge clk);
      bus.xof_squeeze_data_i = beat_of(8'h00); bus.xof_squeeze_valid_i = 1'b1;
      bus.xof_squeeze_last_i = 1'b0; bus.triple_ready_i = 1'b1; #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL first_idle: got %h expected %h", act[31:24], exp[31:24]); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; #1;
         s = 8'(3*i);
         act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'(16-3*i), s+8'd2, s+8'd1, s}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL first_triple%0d: got %h expected %h", i, act, exp); end
      end
      @(negedge clk); #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd1, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL first_drain: got %h expected %h", act[31:24], exp[31:24]); end
   endtask

   task automatic test_straddle();
      logic [7:0] s;
      @(negedge clk); bus.xof_squeeze_data_i = beat_of(8'h10); bus.xof_squeeze_valid_i = 1'b1; #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; #1;
         s = 8'h0F + 8'(3*i);
         act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'(17-3*i), s+8'd2, s+8'd1, s}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL strad1_triple%0d: got %h expected %h", i, act, exp); end
      end
      @(negedge clk); bus.xof_squeeze_data_i = beat_of(8'h20); bus.xof_squeeze_valid_i = 1'b1; #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd2, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL strad_occ2: got %h expected %h", act[31:24], exp[31:24]); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; #1;
         s = 8'h1E + 8'(3*i);
         act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'(18-3*i), s+8'd2, s+8'd1, s}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL strad2_triple%0d: got %h expected %h", i, act, exp); end
      end
      @(negedge clk); #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL strad_occ0: got %h expected %h", act[31:24], exp[31:24]); end
   endtask

   task automatic test_flush();
      @(negedge clk); bus.xof_squeeze_data_i = beat_of(8'h40); bus.xof_squeeze_valid_i = 1'b1; bus.triple_ready_i = 1'b1;
      @(negedge clk); bus.xof_squeeze_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk); bus.triple_ready_i = 1'b0; #1;
      act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'd10, 24'h484746}; n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL flush_occ10: got %h expected %h", act, exp); end
      @(negedge clk); bus.flush_i = 1'b1; bus.xof_squeeze_valid_i = 1'b1; bus.xof_squeeze_data_i = beat_of(8'h60); #1;
      act = obs(); exp = {1'b0, 1'b0, 1'b0, 5'd10, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL flush_masks: got %h expected %h", act[31:24], exp[31:24]); end
      @(negedge clk); bus.flush_i = 1'b0; #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL flush_cleared: got %h expected %h", act[31:24], exp[31:24]); end
      @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; #1;
      act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'd16, 24'h626160}; n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL flush_then_accept: got %h expected %h", act, exp); end
      @(negedge clk); bus.flush_i = 1'b1;
      @(negedge clk); bus.flush_i = 1'b0; bus.triple_ready_i = 1'b1; #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL flush_empty: got %h expected %h", act[31:24], exp[31:24]); end
   endtask

   task automatic test_last();
      logic [7:0] s;
      @(negedge clk); bus.xof_squeeze_data_i = beat_of(8'h00); bus.xof_squeeze_valid_i = 1'b1;
      bus.xof_squeeze_last_i = 1'b1; bus.triple_ready_i = 1'b1; #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; bus.xof_squeeze_last_i = 1'b0; #1;
         s = 8'(3*i);
         act = obs(); exp = {1'b0, 1'b1, 1'(i == 4), 5'(16-3*i), s+8'd2, s+8'd1, s}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL last_triple%0d: got %h expected %h", i, act, exp); end
      end
      @(negedge clk); #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd0, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL last_drop_residual: got %h expected %h", act[31:24], exp[31:24]); end
   endtask

   task automatic test_backpressure();
      logic [7:0] s;
      @(negedge clk); bus.xof_squeeze_data_i = beat_of(8'h00); bus.xof_squeeze_valid_i = 1'b1; bus.triple_ready_i = 1'b1;
      @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; #1;
      act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'd16, 24'h020100}; n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL bp_first: got %h expected %h", act, exp); end
      @(negedge clk); bus.triple_ready_i = 1'b0; bus.xof_squeeze_valid_i = 1'b1; bus.xof_squeeze_data_i = beat_of(8'hA0);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) begin @(negedge clk); bus.triple_ready_i = 1'b1; end
         else if (c > 0) @(negedge clk);
         #1;
         act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'd13, 24'h050403}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL bp_hold%0d: got %h expected %h", c, act, exp); end
      end
      bus.xof_squeeze_valid_i = 1'b0;
      for (int i = 2; i < 5; i++) begin
         @(negedge clk); #1;
         s = 8'(3*i);
         act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'(16-3*i), s+8'd2, s+8'd1, s}; n_checks++;
         if (act !== exp) begin n_fail++; $display("FAIL bp_triple%0d: got %h expected %h", i, act, exp); end
      end
      @(negedge clk); #1;
      act = obs(); exp = {1'b1, 1'b0, 1'b0, 5'd1, 24'h0}; n_checks++;
      if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL bp_drain: got %h expected %h", act[31:24], exp[31:24]); end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk); bus.flush_i = 1'b1;
      @(negedge clk); bus.flush_i = 1'b0; bus.xof_squeeze_data_i = beat_of(8'h80);
      bus.xof_squeeze_valid_i = 1'b1; bus.xof_squeeze_last_i = 1'b1;
      @(negedge clk); bus.xof_squeeze_valid_i = 1'b0; bus.xof_squeeze_last_i = 1'b0; bus.triple_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); bus.triple_ready_i = 1'b0; #1;
      act = obs(); exp = {1'b0, 1'b1, 1'b0, 5'd7, 24'h8B8A89}; n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL mid_occ7: got %h expected %h", act, exp); end
      #2 rst_n = 1'b0; #1;
      act = obs(); n_checks++;
      if (act !== 32'h0) begin n_fail++; $display("FAIL mid_async_reset: got %h expected %h", act, 32'h0); end
      @(negedge clk); rst_n = 1'b1;
      test_first_beat();
   endtask

   task automatic test_random();
      logic [7:0]   q[$];
      bit           lp;
      bit           e_sr, e_v, e_l;
      logic [127:0] d;
      @(negedge clk); bus.flush_i = 1'b1; bus.xof_squeeze_valid_i = 1'b0;
      q.delete(); lp = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         bus.xof_squeeze_data_i  = d;
         bus.xof_squeeze_valid_i = ($urandom_range(0, 2) != 0);
         bus.xof_squeeze_last_i  = ($urandom_range(0, 5) == 0);
         bus.triple_ready_i      = ($urandom_range(0, 3) != 0);
         bus.flush_i             = ($urandom_range(0, 29) == 0);
         #1;
         e_sr = !bus.flush_i && (q.size() <= 2);
         e_v  = !bus.flush_i && (q.size() >= 3);
         e_l  = lp && (q.size() >= 3) && (q.size() <= 5);
         act = obs(); exp = {e_sr, e_v, e_l, 5'(q.size()), 24'h0}; n_checks++;
         if (act[31:24] !== exp[31:24]) begin n_fail++; $display("FAIL rand_ctrl@%0d: got %h expected %h", cyc, act[31:24], exp[31:24]); end
         if (e_v) begin
            exp[23:0] = {q[2], q[1], q[0]}; n_checks++;
            if (act[23:0] !== exp[23:0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, act[23:0], exp[23:0]); end
         end
         if (bus.flush_i) begin
            q.delete(); lp = 1'b0;
         end else if (bus.xof_squeeze_valid_i && e_sr) begin
            for (int k = 0; k < 16; k++) q.push_back(d[8*k +: 8]);
            if (bus.xof_squeeze_last_i) lp = 1'b1;
         end else if (e_v && bus.triple_ready_i) begin
            if (e_l) begin q.delete(); lp = 1'b0; end
            else repeat (3) void'(q.pop_front());
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_beat();
      test_straddle();
      test_flush();
      test_last();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/xof_triple_unpacker.md
# xof_triple_unpacker

Byte-stream adapter between the Keccak core's 128-bit squeeze port and the `sample_ntt` rejection sampler. It accepts 16-byte squeeze beats, buffers them, and emits consecutive 3-byte groups (C[0], C[1], C[2]) with a valid/ready handshake. Groups that straddle beat boundaries are reassembled, so no squeezed bytes are skipped. The sampler consumes every XOF byte instead of only the low 24 bits of each beat.

## Interface
- `IN_BYTES`, 16: bytes per squeeze beat; the block is built for exactly 16.
- `OCC_W`, 5: occupancy counter width; holds 0..18.

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `xof_squeeze_data_i`  in  128  squeeze beat; byte k = bits [8k+7:8k]; byte 0 comes first in the stream.
- `xof_squeeze_valid_i`  in  1  beat valid.
- `xof_squeeze_last_i`  in  1  final beat of the squeeze stream.
- `xof_squeeze_ready_o`  out  1  beat accepted when valid && ready at a rising edge.
- `triple_data_o`  out  24  {C[2], C[1], C[0]}; C[0] = oldest byte, in bits [7:0].
- `triple_valid_o`  out  1  a full triple is available.
- `triple_last_o`  out  1  this is the final triple of a `last` beat.
- `triple_ready_i`  in  1  consumer accepts the triple.
- `flush_i`  in  1  level; discard all buffered bytes (driven by the sampler's stop / restart).
- `occupancy_o`  out  OCC_W  buffered byte count.

## Operation
- Byte buffer of 18 bytes, `occ` in 0..18, plus flag `last_pend`.
- `xof_squeeze_ready_o` = rst_n && !flush_i && (occ <= 2). It is combinational from registers and is never dependent on `xof_squeeze_valid_i`.
- Beat accept: the 16 bytes are written at buffer byte positions occ..occ+15, and occ += 16. If `xof_squeeze_last_i` is high, `last_pend` is set to 1.
- `triple_valid_o` = !flush_i && (occ >= 3). `triple_data_o` = buffer bytes [2:0].
- Pop (valid && ready): the buffer shifts down 3 bytes and occ -= 3.
- `triple_last_o` = `last_pend` && (3 <= occ <= 5).
- Pop with `triple_last_o` high:
  - occ is set to 0; the 0-2 residual bytes are discarded.
  - `last_pend` is cleared.
- Accept and pop never happen in the same cycle, because ready requires occ <= 2 and valid requires occ >= 3.
- `flush_i` high:
  - At the next edge, occ = 0, `last_pend` = 0, and buffer contents are don't-care.
  - While `flush_i` is high, there is no accept and no pop.
  - A flush takes priority over a beat or pop presented in the same cycle.
- Unused buffer bytes above occ are don't-care. The bench compares `triple_data_o` only while `triple_valid_o` is high.

## Timing
- Reset (async assert):
  - occ = 0, `last_pend` = 0, buffer = 0.
  - `xof_squeeze_ready_o` = 0 while rst_n is low.
  - `triple_valid_o` = 0, `triple_last_o` = 0, `triple_data_o` = 0, `occupancy_o` = 0.
  - Reset applied mid-stream discards everything immediately.
- Latency: a beat accepted at edge k gives its first triple in cycle k+1 (one cycle after the edge). Data is not passed combinationally.
- Steady state with `triple_ready_i` held high:
  - Occupancy 0 before the beat: 5 pops in cycles k+1..k+5, leaving occ = 1, and ready is high in cycle k+6.
  - Occupancy 1 before the beat: 17 bytes → 5 triples, leaving occ = 2.
  - Occupancy 2 before the beat: 18 bytes → 6 triples, leaving occ = 0.
- Backpressure: while `triple_ready_i` is low, `triple_data_o`, `triple_valid_o` and `triple_last_o` are held stable.
- The upstream may hold `xof_squeeze_valid_i` indefinitely. A beat is accepted only on a valid && ready edge.
- `xof_squeeze_last_i` is ignored unless the beat is accepted.

## Test plan
- Beat of bytes 0x00..0x0F (`xof_squeeze_data_i` = 0x0F0E…0100), consumer ready → triples 0x020100, 0x050403, 0x080706, 0x0B0A09, 0x0E0D0C in 5 consecutive cycles; occupancy 1; ready high the following cycle.
- Follow-up beats 0x10..0x1F then 0x20..0x2F → 0x11100F first. After the second beat's triples drain, occupancy is 2 (0x1E, 0x1F). The first triple of the third beat is 0x201F1E, and the third beat yields 6 triples ending at occupancy 0.
- `triple_ready_i` low for 3 cycles after the second triple → data 0x050403 held with valid high; squeeze ready stays 0; no byte lost or duplicated across the 5 triples.
- Beat 0x00..0x0F with last=1 from occupancy 0 → 5 triples; only 0x0E0D0C has `triple_last_o` = 1; byte 0x0F is dropped; occupancy 0; ready high.
- `flush_i` pulsed with occupancy 10 and a valid beat presented in the same cycle → beat not accepted; next cycle occupancy 0, valid 0; the beat is accepted on the following cycle.
- rst_n asserted with occupancy 7 and `last_pend` set → all outputs go to reset values without waiting for a clock. After release, a fresh beat 0x00..0x0F reproduces the first scenario.
